// File: rtl/io_bridge_fl.sv
// I/O bridge for the floating-point core: per-channel input holding registers and a tagged output FIFO.
// Optional `IO_OVF_CNT_EN adds an 8-bit saturating drop counter on port ovf_cnt.
module io_bridge_fl #(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 2,
    localparam int W  = NBMANT + NBEXPO + 1,
    localparam int AI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int AO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [W-1:0]      io_in,
    input  logic [AI-1:0]     addr_in,
    input  logic              req_in,
    input  logic [W-1:0]      data_out,
    input  logic [AO-1:0]     addr_out,
    input  logic              out_en,
    input  logic [W-1:0]      in_wr_data,
    input  logic [AI-1:0]     in_wr_addr,
    input  logic              in_wr_valid,
    output logic              in_wr_ready,
    output logic [NUIOIN-1:0] in_fresh,
    output logic [W-1:0]      ou_data,
    output logic [AO-1:0]     ou_addr,
    output logic              ou_valid,
    input  logic              ou_ready,
    output logic              ovf,
    input  logic              ovf_clr
`ifdef IO_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt
`endif
);

    localparam int DEPTH = 2 ** FDEPTH;

    typedef struct packed {
        logic [AO-1:0] addr;
        logic [W-1:0]  data;
    } fifo_ent_t;

    // ---------------- input side ----------------
    logic [W-1:0] in_reg [NUIOIN];
    logic         rd_ok;
    logic         wr_ok;
    logic         wr_fire;

    assign rd_ok   = int'(addr_in) < NUIOIN;
    assign wr_ok   = int'(in_wr_addr) < NUIOIN;
    assign wr_fire = in_wr_valid & in_wr_ready;

    always_comb begin
        io_in       = '0;
        in_wr_ready = 1'b0;
        if (rd_ok)
            io_in = in_reg[addr_in];
        // A channel being consumed this cycle may be refilled in the same cycle.
        if (wr_ok)
            in_wr_ready = ~in_fresh[in_wr_addr] | (req_in & rd_ok & (addr_in == in_wr_addr));
    end

    // NOTE: in_reg is a register array but is reset anyway, because io_in must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUIOIN; i++)
                in_reg[i] <= '0;
            in_fresh <= '0;
        end else begin
            if (req_in && rd_ok)
                in_fresh[addr_in] <= 1'b0;
            // NOTE: non-blocking assignments; the later write below overrides the clear on a collision.
            if (wr_fire) begin
                in_reg[in_wr_addr]   <= in_wr_data;
                in_fresh[in_wr_addr] <= 1'b1;
            end
        end
    end

    // ---------------- output FIFO ----------------
    fifo_ent_t         mem [DEPTH];
    logic [FDEPTH-1:0] wptr;
    logic [FDEPTH-1:0] rptr;
    logic [FDEPTH:0]   count;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    assign ou_valid = count != '0;
    assign full     = count == (FDEPTH + 1)'(DEPTH);
    assign pop      = ou_valid & ou_ready;
    assign push     = out_en & (~full | pop);
    assign drop     = out_en & full & ~pop;
    assign ou_data  = ou_valid ? mem[rptr].data : '0;
    assign ou_addr  = ou_valid ? mem[rptr].addr : '0;

    // NOTE: FIFO storage has no reset; empty-state outputs are forced to 0 instead.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{addr: addr_out, data: data_out};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

`ifdef IO_OVF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_cnt <= '0;
        else if (drop) begin
            if (ovf_clr)
                ovf_cnt <= 8'd1;
            else if (ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 8'd1;
        end else if (ovf_clr)
            ovf_cnt <= '0;
    end
`endif

endmodule

// File: tb/tb_io_bridge_fl.sv
// Bench for io_bridge_fl: directed input-side checks plus a queue scoreboard on the output FIFO.
// Define IO_OVF_CNT_EN for both files to exercise the drop counter.
module tb_io_bridge_fl;

    localparam int W  = 23;
    localparam int AI = 3;
    localparam int AO = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  io_in;
    logic [AI-1:0] addr_in;
    logic          req_in;
    logic [W-1:0]  data_out;
    logic [AO-1:0] addr_out;
    logic          out_en;
    logic [W-1:0]  in_wr_data;
    logic [AI-1:0] in_wr_addr;
    logic          in_wr_valid;
    logic          in_wr_ready;
    logic [7:0]    in_fresh;
    logic [W-1:0]  ou_data;
    logic [AO-1:0] ou_addr;
    logic          ou_valid;
    logic          ou_ready;
    logic          ovf;
    logic          ovf_clr;
`ifdef IO_OVF_CNT_EN
    logic [7:0]    ovf_cnt;
`endif

    io_bridge_fl dut (
        .clk(clk), .rst(rst), .io_in(io_in), .addr_in(addr_in), .req_in(req_in),
        .data_out(data_out), .addr_out(addr_out), .out_en(out_en),
        .in_wr_data(in_wr_data), .in_wr_addr(in_wr_addr), .in_wr_valid(in_wr_valid),
        .in_wr_ready(in_wr_ready), .in_fresh(in_fresh), .ou_data(ou_data),
        .ou_addr(ou_addr), .ou_valid(ou_valid), .ou_ready(ou_ready),
        .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef IO_OVF_CNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AO-1:0] a;
        logic [W-1:0]  d;
    } ent_t;
    ent_t exp_q[$];

    // Monitor: every accepted head is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && ou_valid && ou_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL fifo_unexpected: got addr %0d data 0x%0h, none expected", ou_addr, ou_data);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("fifo_head", {6'd0, ou_addr, ou_data}, {6'd0, e.a, e.d});
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [AO-1:0] a, input logic [W-1:0] d, input bit expect_kept);
        out_en   = 1'b1;
        addr_out = a;
        data_out = d;
        if (expect_kept)
            exp_q.push_back('{a: a, d: d});
    endtask

    initial begin
        rst = 1'b1; addr_in = '0; req_in = 1'b0; data_out = '0; addr_out = '0; out_en = 1'b0;
        in_wr_data = '0; in_wr_addr = '0; in_wr_valid = 1'b0; ou_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) step();
        sample();
        check("rst_ou_valid", 32'(ou_valid), 32'd0);
        check("rst_in_fresh", 32'(in_fresh), 32'd0);
        check("rst_io_in", 32'(io_in), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_wr_ready", 32'(in_wr_ready), 32'd1);
        check("rst_ou_data", {6'd0, ou_addr, ou_data}, 32'd0);
        step();
        rst = 1'b0;

        // T2: input consume
        in_wr_addr = 3'd3; in_wr_data = 23'h12345; in_wr_valid = 1'b1;
        sample();
        check("t2_ready_empty", 32'(in_wr_ready), 32'd1);
        step();
        in_wr_valid = 1'b0;
        sample();
        check("t2_fresh_set", 32'(in_fresh[3]), 32'd1);
        check("t2_ready_full", 32'(in_wr_ready), 32'd0);
        step();
        req_in = 1'b1; addr_in = 3'd3;
        sample();
        check("t2_io_in", 32'(io_in), 32'h12345);
        check("t2_ready_on_req", 32'(in_wr_ready), 32'd1);
        step();
        req_in = 1'b0;
        sample();
        check("t2_fresh_clr", 32'(in_fresh[3]), 32'd0);
        check("t2_stale_read", 32'(io_in), 32'h12345);

        // T3: write/read collision
        step();
        in_wr_addr = 3'd5; in_wr_data = 23'hAAAA; in_wr_valid = 1'b1;
        step();
        in_wr_data = 23'hBBBB; req_in = 1'b1; addr_in = 3'd5;
        sample();
        check("t3_ready", 32'(in_wr_ready), 32'd1);
        check("t3_old_word", 32'(io_in), 32'hAAAA);
        step();
        in_wr_valid = 1'b0; req_in = 1'b0;
        sample();
        check("t3_new_word", 32'(io_in), 32'hBBBB);
        check("t3_fresh", 32'(in_fresh[5]), 32'd1);

        // T4: FIFO order and latency
        step();
        ou_ready = 1'b1;
        push_word(3'd1, 23'd10, 1'b1);
        sample();
        check("t4_latency", 32'(ou_valid), 32'd0);
        step();
        push_word(3'd2, 23'd20, 1'b1);
        sample();
        check("t4_valid", 32'(ou_valid), 32'd1);
        step();
        push_word(3'd7, 23'd70, 1'b1);
        step();
        out_en = 1'b0;
        repeat (3) step();
        sample();
        check("t4_empty", 32'(ou_valid), 32'd0);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // T5: overflow
        step();
        ou_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_word(AO'(i), W'(32'h100 + i), i < 4);
            if (i == 4) begin
                sample();
                check("t5_ovf_before", 32'(ovf), 32'd0);
            end
            step();
        end
        push_word(3'd6, 23'h555, 1'b1);
        ou_ready = 1'b1;
        sample();
        check("t5_ovf_set", 32'(ovf), 32'd1);
        step();
        out_en = 1'b0; ou_ready = 1'b0;
        sample();
        check("t5_still_full", 32'(ou_valid), 32'd1);
`ifdef IO_OVF_CNT_EN
        check("t5_cnt_one", 32'(ovf_cnt), 32'd1);
`endif
        step();
        ovf_clr = 1'b1;
        push_word(3'd5, 23'h777, 1'b0);
        step();
        ovf_clr = 1'b0; out_en = 1'b0;
        sample();
        check("t5_set_wins", 32'(ovf), 32'd1);
`ifdef IO_OVF_CNT_EN
        check("t5_cnt_set_wins", 32'(ovf_cnt), 32'd1);
`endif
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        sample();
        check("t5_ovf_clr", 32'(ovf), 32'd0);
`ifdef IO_OVF_CNT_EN
        check("t5_cnt_clr", 32'(ovf_cnt), 32'd0);
`endif
        step();
        ou_ready = 1'b1;
        repeat (6) step();
        sample();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

`ifdef IO_OVF_CNT_EN
        // T6: counter saturation
        step();
        ou_ready = 1'b0;
        for (int i = 0; i < 304; i++) begin
            push_word(3'd4, W'(i), i < 4);
            step();
        end
        out_en = 1'b0;
        sample();
        check("t6_cnt_sat", 32'(ovf_cnt), 32'd255);
        check("t6_ovf", 32'(ovf), 32'd1);
        step();
        ou_ready = 1'b1; ovf_clr = 1'b1;
        repeat (6) step();
        ovf_clr = 1'b0;
        sample();
        check("t6_drained", 32'(exp_q.size()), 32'd0);
`endif

        // T1: asynchronous reset mid-stream
        step();
        ou_ready = 1'b0;
        in_wr_addr = 3'd2; in_wr_data = 23'h2222; in_wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_word(3'd2, W'(i + 1), 1'b0);
            step();
            in_wr_valid = 1'b0;
        end
        out_en = 1'b0; addr_in = 3'd2;
        sample();
        check("t1_pre_valid", 32'(ou_valid), 32'd1);
        check("t1_pre_fresh", 32'(in_fresh[2]), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_ou_valid", 32'(ou_valid), 32'd0);
        check("t1_in_fresh", 32'(in_fresh), 32'd0);
        check("t1_io_in", 32'(io_in), 32'd0);
        check("t1_ovf", 32'(ovf), 32'd0);
        step();
        rst = 1'b0;
        step();
        sample();
        check("t1_post_valid", 32'(ou_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
